// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and helpers for the shared-adder scheduler
package adder_share_pkg;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] CHAIN = 1'b1;

    // A single requester still needs a one-bit tag so ports never collapse to zero width.
    function automatic int tag_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int onehot_to_idx(input logic [7:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = idx | i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/adder_share_sched_rr_pick.sv
// rtl/adder_share_sched_rr_pick.sv - combinational round-robin picker
module rr_pick
    import adder_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAGW  = tag_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [TAGW-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [TAGW-1:0]  idx,
    output logic             any
);

    logic [7:0] gnt8;

    // Scan upward from the pointer, wrapping, and keep the first hit.
    always_comb begin
        logic            found;
        logic [TAGW-1:0] k;
        gnt   = '0;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = TAGW'((int'(ptr) + i) % N_REQ);
            if (!found && req[k]) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign gnt8 = 8'(gnt);
    assign idx  = TAGW'(onehot_to_idx(gnt8));
    assign any  = |req;

endmodule

// File: rtl/adder_share_sched.sv
// rtl/adder_share_sched.sv - round-robin scheduler for one shared chained adder
module adder_share_sched
    import adder_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int TAGW  = tag_width(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       last,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    input  logic [N_REQ-1:0]       cin_in,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_cin,
    input  logic [WIDTH-1:0]       add_sum,
    input  logic                   add_cout,
    output logic                   res_valid,
    output logic [WIDTH-1:0]       res_sum,
    output logic                   res_cout,
    output logic [TAGW-1:0]        res_tag,
    output logic                   res_last
);

    logic [0:0]       state_q;
    logic [TAGW-1:0]  ptr_q;
    logic [TAGW-1:0]  owner_q;
    logic             carry_q;

    logic [N_REQ-1:0] pick_gnt;
    logic [TAGW-1:0]  pick_idx;
    logic             pick_any;

    logic [TAGW-1:0]  sel;
    logic             grant_any;
    logic [TAGW-1:0]  ptr_next;

    rr_pick #(
        .N_REQ (N_REQ),
        .TAGW  (TAGW)
    ) u_pick (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Outside a chain the picker decides; inside one only the owner may proceed.
    always_comb begin
        gnt     = '0;
        sel     = '0;
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (rst_n && ena) begin
            if (state_q == IDLE) begin
                if (pick_any) begin
                    gnt     = pick_gnt;
                    sel     = pick_idx;
                    add_cin = cin_in[pick_idx];
                end
            end else if (req[owner_q]) begin
                gnt[owner_q] = 1'b1;
                sel          = owner_q;
                add_cin      = carry_q;
            end
        end
        grant_any = |gnt;
        if (grant_any) begin
            add_a = op_a[int'(sel)*WIDTH +: WIDTH];
            add_b = op_b[int'(sel)*WIDTH +: WIDTH];
        end
    end

    assign ptr_next = (sel == TAGW'(N_REQ - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            carry_q   <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_tag   <= '0;
            res_last  <= 1'b0;
        end else begin
            res_valid <= grant_any;
            if (grant_any) begin
                res_sum  <= add_sum;
                res_cout <= add_cout;
                res_tag  <= sel;
                res_last <= last[sel];
                carry_q  <= add_cout;
                if (last[sel]) begin
                    state_q <= IDLE;
                    ptr_q   <= ptr_next;
                end else begin
                    state_q <= CHAIN;
                    owner_q <= sel;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_share_sched.sv
// tb/tb_adder_share_sched.sv - directed self-checking bench for adder_share_sched
module tb_adder_share_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           ena;
    logic [N-1:0]   req;
    logic [N-1:0]   last;
    logic [N*W-1:0] op_a;
    logic [N*W-1:0] op_b;
    logic [N-1:0]   cin_in;
    logic [N-1:0]   gnt;
    logic [W-1:0]   add_a;
    logic [W-1:0]   add_b;
    logic           add_cin;
    logic [W-1:0]   add_sum;
    logic           add_cout;
    logic           res_valid;
    logic [W-1:0]   res_sum;
    logic           res_cout;
    logic [1:0]     res_tag;
    logic           res_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Stand-in for the shared combinational adder.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};

    adder_share_sched #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req       (req),
        .last      (last),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin_in    (cin_in),
        .gnt       (gnt),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .res_valid (res_valid),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_tag   (res_tag),
        .res_last  (res_last)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic l);
        op_a[i*W +: W] = a;
        op_b[i*W +: W] = b;
        cin_in[i]      = c;
        last[i]        = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        last  = 4'b1111;
        step();
        step();
        checks++;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
        checks++;
        if ({res_valid, res_sum, res_cout, res_tag, res_last} !== 13'd0) begin
            errors++;
            $display("FAIL reset_res got v=%b s=%h c=%b t=%0d l=%b exp all zero",
                     res_valid, res_sum, res_cout, res_tag, res_last);
        end
        req   = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < N; i++) set_op(i, 8'(i), 8'h10, 1'b0, 1'b1);
        req = 4'b1111;
        #1;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (gnt !== 4'(1 << (i % 4))) begin
                errors++;
                $display("FAIL rr_gnt[%0d] got %b exp %b", i, gnt, 4'(1 << (i % 4)));
            end
            step();
            checks++;
            if (res_valid !== 1'b1 || res_tag !== 2'(i % 4) || res_sum !== 8'(8'h10 + i % 4)) begin
                errors++;
                $display("FAIL rr_res[%0d] got v=%b t=%0d s=%h exp v=1 t=%0d s=%h",
                         i, res_valid, res_tag, res_sum, i % 4, 8'(8'h10 + i % 4));
            end
        end
        req = '0;
        step();
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL rr_idle got %b exp 0", res_valid); end
    endtask

    task automatic test_single();
        set_op(0, 8'h3C, 8'h15, 1'b1, 1'b1);
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001 || add_a !== 8'h3C || add_b !== 8'h15 || add_cin !== 1'b1) begin
            errors++;
            $display("FAIL single_drive got g=%b a=%h b=%h c=%b exp g=0001 a=3c b=15 c=1",
                     gnt, add_a, add_b, add_cin);
        end
        step();
        req = '0;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h52 || res_cout !== 1'b0 || res_tag !== 2'd0 || res_last !== 1'b1) begin
            errors++;
            $display("FAIL single_res got v=%b s=%h c=%b t=%0d l=%b exp v=1 s=52 c=0 t=0 l=1",
                     res_valid, res_sum, res_cout, res_tag, res_last);
        end
        step();
        checks++;
        if (res_valid !== 1'b0 || res_sum !== 8'h52) begin
            errors++;
            $display("FAIL single_hold got v=%b s=%h exp v=0 s=52", res_valid, res_sum);
        end
    endtask

    task automatic test_chain();
        // Pointer is 1 here; a single beat on requester 1 moves it to 2.
        set_op(1, 8'h11, 8'h22, 1'b0, 1'b1);
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL chain_pre_gnt got %b exp 0010", gnt); end
        step();
        set_op(2, 8'hFF, 8'h01, 1'b0, 1'b0);
        req = 4'b0110;
        #1;
        checks++;
        if (gnt !== 4'b0100 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL chain_b1_gnt got g=%b c=%b exp g=0100 c=0", gnt, add_cin);
        end
        checks++;
        if (res_sum !== 8'h33 || res_tag !== 2'd1) begin
            errors++;
            $display("FAIL chain_pre_res got s=%h t=%0d exp s=33 t=1", res_sum, res_tag);
        end
        step();
        set_op(2, 8'h01, 8'h00, 1'b0, 1'b1);
        #1;
        checks++;
        if (gnt !== 4'b0100 || add_cin !== 1'b1) begin
            errors++;
            $display("FAIL chain_b2_gnt got g=%b c=%b exp g=0100 c=1", gnt, add_cin);
        end
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h00 || res_cout !== 1'b1 || res_tag !== 2'd2 || res_last !== 1'b0) begin
            errors++;
            $display("FAIL chain_b1_res got v=%b s=%h c=%b t=%0d l=%b exp v=1 s=00 c=1 t=2 l=0",
                     res_valid, res_sum, res_cout, res_tag, res_last);
        end
        step();
        req = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL chain_after_gnt got %b exp 0010", gnt); end
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h02 || res_cout !== 1'b0 || res_tag !== 2'd2 || res_last !== 1'b1) begin
            errors++;
            $display("FAIL chain_b2_res got v=%b s=%h c=%b t=%0d l=%b exp v=1 s=02 c=0 t=2 l=1",
                     res_valid, res_sum, res_cout, res_tag, res_last);
        end
        step();
        req = '0;
        step();
    endtask

    task automatic test_stall_ena();
        // Pointer is 2, so requester 0 wins after wrapping.
        set_op(0, 8'hFF, 8'h01, 1'b0, 1'b0);
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL stall_b1_gnt got %b exp 0001", gnt); end
        step();
        req = 4'b0100;
        #1;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h00 || res_cout !== 1'b1) begin
            errors++;
            $display("FAIL stall_b1_res got v=%b s=%h c=%b exp v=1 s=00 c=1", res_valid, res_sum, res_cout);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (gnt !== 4'b0000) begin errors++; $display("FAIL stall_gnt[%0d] got %b exp 0000", i, gnt); end
            step();
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 0", i, res_valid); end
        end
        set_op(0, 8'h00, 8'h00, 1'b0, 1'b1);
        req = 4'b0001;
        ena = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gnt !== 4'b0000 || add_a !== 8'h00 || add_cin !== 1'b0) begin
                errors++;
                $display("FAIL ena_gnt[%0d] got g=%b a=%h c=%b exp 0", i, gnt, add_a, add_cin);
            end
            step();
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL ena_valid[%0d] got %b exp 0", i, res_valid); end
        end
        ena = 1'b1;
        #1;
        checks++;
        if (gnt !== 4'b0001 || add_cin !== 1'b1) begin
            errors++;
            $display("FAIL stall_b2_gnt got g=%b c=%b exp g=0001 c=1", gnt, add_cin);
        end
        step();
        req = '0;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h01 || res_cout !== 1'b0 || res_tag !== 2'd0 || res_last !== 1'b1) begin
            errors++;
            $display("FAIL stall_b2_res got v=%b s=%h c=%b t=%0d l=%b exp v=1 s=01 c=0 t=0 l=1",
                     res_valid, res_sum, res_cout, res_tag, res_last);
        end
        step();
    endtask

    task automatic test_reset_mid_chain();
        // Pointer is 1; requester 3 is the only one asking.
        set_op(3, 8'hFF, 8'hFF, 1'b1, 1'b0);
        req = 4'b1000;
        #1;
        checks++;
        if (gnt !== 4'b1000) begin errors++; $display("FAIL rmid_b1_gnt got %b exp 1000", gnt); end
        step();
        req   = '0;
        rst_n = 1'b0;
        step();
        checks++;
        if ({res_valid, res_sum, res_cout, res_tag, res_last} !== 13'd0 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL rmid_reset got v=%b s=%h c=%b t=%0d l=%b g=%b exp all zero",
                     res_valid, res_sum, res_cout, res_tag, res_last, gnt);
        end
        rst_n = 1'b1;
        set_op(3, 8'h10, 8'h10, 1'b0, 1'b1);
        req = 4'b1000;
        #1;
        checks++;
        if (gnt !== 4'b1000 || add_cin !== 1'b0) begin
            errors++;
            $display("FAIL rmid_new_gnt got g=%b c=%b exp g=1000 c=0", gnt, add_cin);
        end
        step();
        req = '0;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'h20 || res_cout !== 1'b0 || res_tag !== 2'd3 || res_last !== 1'b1) begin
            errors++;
            $display("FAIL rmid_new_res got v=%b s=%h c=%b t=%0d l=%b exp v=1 s=20 c=0 t=3 l=1",
                     res_valid, res_sum, res_cout, res_tag, res_last);
        end
        step();
    endtask

    task automatic test_overflow();
        set_op(0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        req = 4'b0001;
        step();
        req = '0;
        checks++;
        if (res_valid !== 1'b1 || res_sum !== 8'hFF || res_cout !== 1'b1 || res_tag !== 2'd0) begin
            errors++;
            $display("FAIL overflow got v=%b s=%h c=%b t=%0d exp v=1 s=ff c=1 t=0",
                     res_valid, res_sum, res_cout, res_tag);
        end
        step();
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        req    = '0;
        last   = '0;
        op_a   = '0;
        op_b   = '0;
        cin_in = '0;
        #1;
        test_reset();
        test_round_robin();
        test_single();
        test_chain();
        test_stall_ena();
        test_reset_mid_chain();
        test_overflow();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_share_sched.md
Name: adder_share_sched

Overview:
- Time-multiplexes one shared WIDTH-bit parallel adder (the existing tt_um_parallel_adder datapath) among N_REQ requesters.
- Arbitration is round-robin.
- Supports multi-beat chained additions: the carry of one beat feeds the next beat of the same requester, so operands wider than WIDTH are added beat by beat, LSB first.
- Sits between requester logic and the combinational adder. Drives the adder operands and registers the adder result together with the requester tag.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/sum width of the shared adder.
- TAGW, $clog2(N_REQ), width of the requester tag. Derived; not overridden.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  design enable; low freezes scheduling.
- req  in  N_REQ  per-requester beat request; held until granted.
- last  in  N_REQ  per-requester: this beat ends the chained operation.
- op_a  in  N_REQ*WIDTH  per-requester operand A, slice i = requester i.
- op_b  in  N_REQ*WIDTH  per-requester operand B.
- cin_in  in  N_REQ  per-requester carry-in, used on the first beat only.
- gnt  out  N_REQ  one-hot accept; the beat is consumed in the cycle gnt[i]=1.
- add_a  out  WIDTH  to shared adder, operand A.
- add_b  out  WIDTH  to shared adder, operand B.
- add_cin  out  1  to shared adder, carry-in.
- add_sum  in  WIDTH  from shared adder (combinational).
- add_cout  in  1  from shared adder.
- res_valid  out  1  registered result valid, one-cycle pulse per beat.
- res_sum  out  WIDTH  registered sum.
- res_cout  out  1  registered carry-out.
- res_tag  out  TAGW  index of the requester that owns the result.
- res_last  out  1  copy of last for this beat.

Behaviour:
- Reset (rst_n=0 at posedge):
  - gnt=0; res_valid=0; res_sum=0; res_cout=0; res_tag=0; res_last=0.
  - State=IDLE; rr pointer=0; carry_q=0; owner=0.
- gnt, add_a, add_b and add_cin are combinational from the current state and the inputs.
- When gnt=0, add_a=0, add_b=0, add_cin=0.
- States:
  - IDLE: no chain in progress.
  - CHAIN: owner locked mid-operation.
- IDLE, ena=1, any req:
  - Winner = first set req bit scanning from the rr pointer upward, wrapping modulo N_REQ.
  - gnt[winner]=1; add_a/add_b = winner slices; add_cin = cin_in[winner].
  - If last[winner]=0: go to CHAIN, owner=winner, carry_q<=add_cout.
  - If last[winner]=1: stay in IDLE, pointer<=(winner+1) mod N_REQ.
- CHAIN, ena=1:
  - Only the owner is eligible; other requests wait.
  - If req[owner]=1: gnt[owner]=1; add_cin=carry_q; cin_in is ignored; carry_q<=add_cout.
    - On last[owner]=1: go to IDLE, pointer<=(owner+1) mod N_REQ.
  - If req[owner]=0: stall with no grant. State, carry_q and lock are held indefinitely; there is no timeout.
- Result latency is 1 cycle. The cycle after any grant: res_valid=1, res_sum=add_sum, res_cout=add_cout, res_tag=granted index, res_last=last[granted]. In every other cycle res_valid=0 and the other res_* outputs hold their values.
- ena=0:
  - gnt=0; nothing is consumed.
  - State, pointer and carry_q are held.
  - res_valid=0 from the next edge.
- Width: sum is modulo 2^WIDTH; carry appears only in res_cout/carry_q. No saturation.
- Single-beat ops (last=1 on the first beat) never enter CHAIN.
- Back-to-back: a new grant is allowed every cycle, so one beat per cycle is the peak throughput.
- Reset mid-chain: the lock and carry are dropped and the block returns to IDLE with pointer 0. The requester is responsible for restarting its operation.
- A req whose last is asserted while in CHAIN for a different owner has no effect until the chain ends.

Decomposition:
- Package adder_share_pkg:
  - state enum {IDLE, CHAIN};
  - function for tag width.
  - function onehot-to-index.
- Sub-module rr_pick (N_REQ):
  - combinational round-robin picker;
  - inputs: request vector and pointer;
  - outputs: one-hot grant, index, any-valid.
- The top module holds the FSM, pointer, carry_q, operand mux and result registers.

Test Plan:
- Single beat: req[0]=1, op_a=0x3C, op_b=0x15, cin=1, last=1 -> gnt[0] that cycle; next cycle res_valid=1, res_sum=0x52, res_cout=0, res_tag=0, res_last=1.
- 16-bit chain on requester 2: 0x01FF+0x0001 as beat 1 (A=0xFF, B=0x01, cin=0, last=0) then beat 2 (A=0x01, B=0x00, last=1) -> results 0x00/cout=1, then 0x02/cout=0, tag=2. Req[1] is held high throughout and is not granted until after beat 2.
- Round-robin: all four req held with last=1 for 8 cycles from reset -> gnt sequence 0,1,2,3,0,1,2,3, one grant per cycle, res_valid high for 8 consecutive cycles.
- Chain stall and ena: mid-chain drop req[owner] for 3 cycles and pulse ena=0 for 2 cycles -> no gnt and res_valid=0 during the gaps; the next beat uses the held carry_q=1 (A=0x00, B=0x00 gives sum 0x01).
- Reset mid-chain: rst_n=0 for 1 cycle after beat 1 of a chain on requester 3 -> all outputs return to reset values. The next single beat from requester 3 uses its own cin_in (0x10+0x10, cin=0 gives 0x20), not the old carry.
- Overflow: op_a=0xFF, op_b=0xFF, cin=1, last=1 -> res_sum=0xFF, res_cout=1.
